// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
// Remote command link endpoint. Receives two-byte command frames over UART
// (high byte first) and presents them as a 16-bit command with a ready flag.
// Serialises a one-byte response back to the remote. RX and TX run fully
// independently (full duplex).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input from remote (asynchronous, idle high)
//   TX           serial output to remote (idle high)
//   cmd          assembled command {high_byte, low_byte}
//   cmd_rdy      full command valid
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp         response byte to send
//   trmt         one-cycle pulse, starts sending resp
//   tx_done      response fully sent (held until next accepted trmt)
//
// Parameter:
//   BAUD_DIV     clocks per bit, must be >= 8
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;
  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;
  typedef enum logic [0:0] {ASM_HIGH = 1'b0, ASM_LOW = 1'b1} asm_state_t;

  // RX synchronizer plus one delay stage for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_start_s, rx_byte_rdy_s, rx_frame_err_s;

  asm_state_t    asm_q, asm_d;
  logic [7:0]    high_q, high_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;

  assign rx_start_s = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

  // Two-flop synchronizer for the asynchronous RX line, preset to idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next state: half-bit delay to the start-bit centre, then one
  // full bit period per sample; sample index 0 = start, 1..8 = data, 9 = stop
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_byte_rdy_s  = 1'b0;
    rx_frame_err_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_start_s) begin
          rx_state_d = RX_RECV;
          rx_cnt_d   = CNT_HALF;
          rx_bit_d   = 4'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d = CNT_FULL;
          if (rx_bit_q == 4'd0) begin
            // Start sample still high: line glitch, abandon the frame
            if (rx_sync_q) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_bit_d = 4'd1;
            end
          end else if (rx_bit_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            if (rx_sync_q) begin
              rx_byte_rdy_s = 1'b1;
            end else begin
              rx_frame_err_s = 1'b1;
            end
          end else begin
            // LSB arrives first, so shift in from the top
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Two-byte assembly; cmd only changes when a complete frame arrives, so the
  // high byte waits in its own register
  always_comb begin
    asm_d  = asm_q;
    high_d = high_q;
    cmd_d  = cmd_q;
    if (clr_cmd_rdy || (rx_start_s && (asm_q == ASM_HIGH))) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
    if (rx_frame_err_s) begin
      // A bad stop bit drops any half-assembled command
      asm_d = ASM_HIGH;
    end else if (rx_byte_rdy_s) begin
      case (asm_q)
        ASM_HIGH: begin
          high_d = rx_shift_q;
          asm_d  = ASM_LOW;
        end
        ASM_LOW: begin
          cmd_d     = {high_q, rx_shift_q};
          cmd_rdy_d = 1'b1;   // set wins over a simultaneous clear
          asm_d     = ASM_HIGH;
        end
        default: begin
          asm_d = ASM_HIGH;
        end
      endcase
    end else begin
      asm_d = asm_q;
    end
  end

  // Transmitter next state: start bit is driven on the accept edge, every bit
  // is held BAUD_DIV clocks, done asserts after the stop bit period
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_shift_d = {1'b1, resp};
          tx_d       = 1'b0;
          tx_done_d  = 1'b0;
          tx_cnt_d   = CNT_FULL_M1;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_SEND;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == CNT_ZERO) begin
          if (tx_bit_q == 4'd9) begin
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_cnt_d   = CNT_FULL_M1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // State registers for receiver, assembly and transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      asm_q      <= ASM_HIGH;
      high_q     <= 8'h00;
      cmd_q      <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 9'h1FF;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      asm_q      <= asm_d;
      high_q     <= high_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper with BAUD_DIV = 16.
module tb_uart_cmd_wrapper;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;

  int checks = 0;
  int failures = 0;

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (rx),
    .TX         (tx),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        stop;
    logic        clr_after;
    logic        exp_rdy;
    logic [15:0] exp_cmd;
  } rx_vec_t;

  rx_vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits bits of a UART frame (start, 8 data LSB first, stop)
  task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      tick(BD);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bits(d, stop, 10);
    rx = 1'b1;
    tick(3);
  endtask

  // One response frame; a second trmt with 8'hFF lands 40 clocks in
  task automatic tx_frame(input logic [7:0] r);
    logic [9:0] exp_bits;
    exp_bits = {1'b1, r, 1'b0};
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int k = 0; k <= 170; k++) begin
      if (k == 0) begin
        check("tx_start_low", {15'd0, tx}, 16'd0);
        check("tx_done_cleared", {15'd0, tx_done}, 16'd0);
      end
      if (k == 40) begin
        resp = 8'hFF;
        trmt = 1'b1;
      end
      if (k == 41) trmt = 1'b0;
      if (k < 160 && (k % BD) == 8)
        check($sformatf("tx_bit%0d", k / BD), {15'd0, tx}, {15'd0, exp_bits[k / BD]});
      if (k == 159) check("tx_done_early", {15'd0, tx_done}, 16'd0);
      if (k == 160) check("tx_done_rise", {15'd0, tx_done}, 16'd1);
      if (k == 170) begin
        check("tx_done_hold", {15'd0, tx_done}, 16'd1);
        check("tx_idle_high", {15'd0, tx}, 16'd1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    //            data   stop  clr   rdy   cmd
    vecs[0]  = '{8'h43, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{8'hF2, 1'b1, 1'b1, 1'b1, 16'h43F2};
    vecs[2]  = '{8'h50, 1'b1, 1'b0, 1'b0, 16'h43F2};
    vecs[3]  = '{8'h01, 1'b1, 1'b0, 1'b1, 16'h5001};
    vecs[4]  = '{8'h77, 1'b1, 1'b0, 1'b0, 16'h5001}; // start bit clears rdy
    vecs[5]  = '{8'h88, 1'b1, 1'b1, 1'b1, 16'h7788};
    vecs[6]  = '{8'hAA, 1'b1, 1'b0, 1'b0, 16'h7788};
    vecs[7]  = '{8'h43, 1'b0, 1'b0, 1'b0, 16'h7788}; // framing error drops AA
    vecs[8]  = '{8'h43, 1'b1, 1'b0, 1'b0, 16'h7788};
    vecs[9]  = '{8'hF2, 1'b1, 1'b0, 1'b1, 16'h43F2};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 16'h43F2};
    vecs[11] = '{8'hFF, 1'b1, 1'b1, 1'b1, 16'h00FF};

    tick(2);
    check("reset_tx", {15'd0, tx}, 16'd1);
    check("reset_cmd", cmd, 16'h0000);
    check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("reset_tx_done", {15'd0, tx_done}, 16'd0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 12; i++) begin
      send_byte(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].exp_cmd);
      check($sformatf("vec%0d_rdy", i), {15'd0, cmd_rdy}, {15'd0, vecs[i].exp_rdy});
      if (vecs[i].clr_after) begin
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check($sformatf("vec%0d_clr", i), {15'd0, cmd_rdy}, 16'd0);
      end
    end

    // Short low glitch must not be taken as a byte
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("glitch_cmd", cmd, 16'h00FF);
    check("glitch_rdy", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h5A, 1'b1);
    check("glitch_hi_only_rdy", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'hC3, 1'b1);
    check("after_glitch_cmd", cmd, 16'h5AC3);
    check("after_glitch_rdy", {15'd0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;

    // Response transmit, twice so the second run sees tx_done clear
    tx_frame(8'hA5);
    tx_frame(8'h3C);

    // Reset in the middle of the low byte and of a TX frame
    send_byte(8'h12, 1'b1);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    send_bits(8'h34, 1'b1, 4);
    check("pre_reset_tx_low", {15'd0, tx}, 16'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {15'd0, tx}, 16'd1);
    check("midrst_cmd", cmd, 16'h0000);
    check("midrst_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("midrst_tx_done", {15'd0, tx_done}, 16'd0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Full frame after reset with cmd_rdy timing around the stop sample
    send_byte(8'h12, 1'b1);
    check("post_rst_hi_rdy", {15'd0, cmd_rdy}, 16'd0);
    send_bits(8'h34, 1'b1, 9);
    rx = 1'b1;
    tick(4);
    check("stop_early_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("stop_early_cmd", cmd, 16'h0000);
    tick(12);
    check("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
    check("post_rst_cmd", cmd, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
